fp_to_int: RTL

//  Downstream consumer of the single-precision adder result stream: converts an IEEE-754 binary32

---
 rtl/fp_to_int_pkg.sv | 33 +++
 rtl/fp_to_int_if.sv | 24 ++
 rtl/fp_to_int_classify.sv | 25 ++
 rtl/fp_to_int.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/fp_to_int_pkg.sv
// Shared binary32 definitions for the float-to-integer converter:
// field positions, exponent constants, FSM state encodings and
// classification helpers.
package fp_to_int_pkg;

  localparam int SIGN_BIT = 31;
  localparam int EXP_HI   = 30;
  localparam int EXP_LO   = 23;
  localparam int FRAC_HI  = 22;
  localparam int BIAS     = 127;
  localparam logic [7:0] EXP_INF = 8'hFF;

  typedef logic [2:0] state_t;
  localparam state_t ST_GET_A   = 3'd0;
  localparam state_t ST_UNPACK  = 3'd1;
  localparam state_t ST_SPECIAL = 3'd2;
  localparam state_t ST_ALIGN   = 3'd3;
  localparam state_t ST_ROUND   = 3'd4;
  localparam state_t ST_PUT_Z   = 3'd5;

  function automatic logic is_nan(input logic [31:0] a);
    return (a[EXP_HI:EXP_LO] == EXP_INF) && (a[FRAC_HI:0] != '0);
  endfunction

  function automatic logic is_inf(input logic [31:0] a);
    return (a[EXP_HI:EXP_LO] == EXP_INF) && (a[FRAC_HI:0] == '0);
  endfunction

  function automatic logic is_zero(input logic [31:0] a);
    return a[EXP_HI:0] == '0;
  endfunction

endpackage

// File: rtl/fp_to_int_if.sv
// Operand and result stb/ack handshake bundle for fp_to_int.
// The master side supplies operands and consumes results.
interface fp_to_int_if #(
  parameter int OUT_W = 32
);
  logic [31:0]             input_a;
  logic                    input_a_stb;
  logic                    input_a_ack;
  logic signed [OUT_W-1:0] output_z;
  logic                    output_invalid;
  logic                    output_inexact;
  logic                    output_z_stb;
  logic                    output_z_ack;

  modport master (
    output input_a, input_a_stb, output_z_ack,
    input  input_a_ack, output_z, output_invalid, output_inexact, output_z_stb
  );

  modport slave (
    input  input_a, input_a_stb, output_z_ack,
    output input_a_ack, output_z, output_invalid, output_inexact, output_z_stb
  );
endinterface

// File: rtl/fp_to_int_classify.sv
// Combinational binary32 field splitter and classifier. Denormals are
// reported with a cleared hidden bit and the minimum exponent.
module fp_to_int_classify
  import fp_to_int_pkg::*;
(
  input  logic [31:0]       a,
  output logic              s,
  output logic signed [9:0] e,
  output logic [23:0]       m,
  output logic              nan,
  output logic              inf,
  output logic              zero
);
  logic [7:0] exp_f;
  logic       hidden;

  assign exp_f  = a[EXP_HI:EXP_LO];
  assign hidden = (exp_f != 8'd0);
  assign s      = a[SIGN_BIT];
  assign e      = hidden ? ($signed({2'b00, exp_f}) - 10'(BIAS)) : -10'sd126;
  assign m      = {hidden, a[FRAC_HI:0]};
  assign nan    = is_nan(a);
  assign inf    = is_inf(a);
  assign zero   = is_zero(a);
endmodule

// File: rtl/fp_to_int.sv
// binary32 -> signed OUT_W-bit integer converter with stb/ack handshakes.
// Multi-cycle FSM, one alignment shift per cycle, saturating on overflow.
// Build option: define ROUND_NEAREST_EN for round-to-nearest-even;
// otherwise results truncate toward zero.
module fp_to_int
  import fp_to_int_pkg::*;
#(
  parameter int OUT_W = 32
) (
  input logic       clk,
  input logic       rst,
  fp_to_int_if.slave bus
);
  localparam logic [OUT_W-1:0] MAX_Z = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MIN_Z = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic signed [9:0] E_TOP   = 10'(OUT_W-1);
  localparam logic signed [9:0] E_ALIGN = 10'sd23;
  localparam logic signed [9:0] E_LOW   = -10'sd1;
  localparam logic [32:0] LIM_POS = (33'd1 << (OUT_W-1)) - 33'd1;
  localparam logic [32:0] LIM_NEG = 33'd1 << (OUT_W-1);
`ifdef ROUND_NEAREST_EN
  localparam logic RNE_EN = 1'b1;
`else
  localparam logic RNE_EN = 1'b0;
`endif

  state_t            state;
  logic [31:0]       a_q;
  logic              s_q, nan_q, inf_q, zero_q;
  logic signed [9:0] e_q;
  logic [31:0]       m_q;
  logic              guard, sticky;

  logic              cls_s, cls_nan, cls_inf, cls_zero;
  logic signed [9:0] cls_e;
  logic [23:0]       cls_m;

  logic [32:0]       mag;
  logic              ovf;
  logic [OUT_W-1:0]  round_z;

  fp_to_int_classify u_classify (
    .a(a_q), .s(cls_s), .e(cls_e), .m(cls_m),
    .nan(cls_nan), .inf(cls_inf), .zero(cls_zero)
  );

  function automatic logic round_inc(input logic g, input logic st, input logic lsb);
    return g & (st | lsb);
  endfunction

  function automatic logic [OUT_W-1:0] sat_value(input logic neg);
    return neg ? MIN_Z : MAX_Z;
  endfunction

  // Rounded magnitude, range check against the sign-dependent limit, and sign application
  always_comb begin
    mag     = {1'b0, m_q} + 33'(RNE_EN & round_inc(guard, sticky, m_q[0]));
    ovf     = mag > (s_q ? LIM_NEG : LIM_POS);
    round_z = s_q ? OUT_W'(33'd0 - mag) : OUT_W'(mag);
    if (ovf) round_z = sat_value(s_q);
  end

  // Operand datapath: capture, unpack, and one-bit-per-cycle alignment toward e == 23
  always_ff @(posedge clk) begin
    case (state)
      ST_GET_A: if (bus.input_a_stb && bus.input_a_ack) a_q <= bus.input_a;
      ST_UNPACK: begin
        s_q    <= cls_s;
        e_q    <= cls_e;
        m_q    <= {8'd0, cls_m};
        nan_q  <= cls_nan;
        inf_q  <= cls_inf;
        zero_q <= cls_zero;
      end
      ST_SPECIAL: begin
        guard  <= 1'b0;
        sticky <= 1'b0;
      end
      ST_ALIGN: begin
        if (e_q < E_ALIGN) begin
          m_q    <= {1'b0, m_q[31:1]};
          guard  <= m_q[0];
          sticky <= sticky | guard;
          e_q    <= e_q + 10'sd1;
        end else if (e_q > E_ALIGN) begin
          m_q <= {m_q[30:0], 1'b0};
          e_q <= e_q - 10'sd1;
        end
      end
      default: ;
    endcase
  end

  // Control FSM, handshakes and registered result/flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= ST_GET_A;
      bus.input_a_ack    <= 1'b0;
      bus.output_z_stb   <= 1'b0;
      bus.output_z       <= '0;
      bus.output_invalid <= 1'b0;
      bus.output_inexact <= 1'b0;
    end else begin
      case (state)
        ST_GET_A: begin
          if (!bus.input_a_ack) begin
            bus.input_a_ack <= 1'b1;
          end else if (bus.input_a_stb) begin
            bus.input_a_ack <= 1'b0;
            state           <= ST_UNPACK;
          end
        end
        ST_UNPACK: state <= ST_SPECIAL;
        ST_SPECIAL: begin
          state              <= ST_PUT_Z;
          bus.output_z_stb   <= 1'b1;
          bus.output_invalid <= 1'b0;
          bus.output_inexact <= 1'b0;
          if (nan_q) begin
            bus.output_z       <= MIN_Z;
            bus.output_invalid <= 1'b1;
          end else if (inf_q) begin
            bus.output_z       <= sat_value(s_q);
            bus.output_invalid <= 1'b1;
          end else if (zero_q) begin
            bus.output_z <= '0;
          end else if (e_q >= E_TOP) begin
            bus.output_z <= sat_value(s_q);
            // -2^(OUT_W-1) itself is representable and exact
            bus.output_invalid <= !(s_q && e_q == E_TOP && m_q == 32'h0080_0000);
          end else if (e_q < E_LOW) begin
            bus.output_z       <= '0;
            bus.output_inexact <= 1'b1;
          end else begin
            state            <= ST_ALIGN;
            bus.output_z_stb <= 1'b0;
          end
        end
        ST_ALIGN: if (e_q == E_ALIGN) state <= ST_ROUND;
        ST_ROUND: begin
          bus.output_z       <= round_z;
          bus.output_invalid <= ovf;
          bus.output_inexact <= guard | sticky;
          bus.output_z_stb   <= 1'b1;
          state              <= ST_PUT_Z;
        end
        ST_PUT_Z: begin
          if (bus.output_z_ack) begin
            bus.output_z_stb <= 1'b0;
            bus.input_a_ack  <= 1'b1;
            state            <= ST_GET_A;
          end
        end
        default: state <= ST_GET_A;
      endcase
    end
  end
endmodule
